// File: rtl/gap_controller.sv
// Sequencing controller for the global-average-pooling unit: clear, stream, wait, emit per channel.
// Define GAP_CTRL_ABORT_EN to add the abort input; without it jobs always run to completion.

module gap_controller #(
  parameter int IL       = 4,
  parameter int FL       = 16,
  parameter int CH_W     = 10,
  parameter int POOL_LAT = 1,
  localparam int W       = IL + FL
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CH_W-1:0]     num_ch,
  input  logic [W-1:0]        size,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_data,
  output logic                pool_en,
  output logic                pool_clr,
  output logic signed [W-1:0] pool_im,
  input  logic signed [W-1:0] pool_om,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic [CH_W-1:0]     out_ch,
`ifdef GAP_CTRL_ABORT_EN
  input  logic                abort,
`endif
  output logic [2:0]          dbg_state_o
);

  localparam int WC_W = (POOL_LAT > 1) ? $clog2(POOL_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    EMIT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t                state_q;
  logic [CH_W-1:0]       num_ch_q;
  logic [W-1:0]          size_q;
  logic [CH_W-1:0]       ch_q;
  logic [W-1:0]          elem_q;
  logic [WC_W-1:0]       wcnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  out_valid_q;
  logic signed [W-1:0]   out_data_q;
  logic [CH_W-1:0]       out_ch_q;
  logic                  abort_hit;

`ifdef GAP_CTRL_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid holds with stable out_data/out_ch until that edge, and in_ready is high only while streaming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_ch_q    <= '0;
      size_q      <= '0;
      ch_q        <= '0;
      elem_q      <= '0;
      wcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_hit) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (num_ch != '0 && size != '0) begin
                num_ch_q <= num_ch;
                size_q   <= size;
                ch_q     <= '0;
                busy_q   <= 1'b1;
                state_q  <= CLEAR;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          CLEAR: begin
            elem_q  <= '0;
            state_q <= STREAM;
          end
          STREAM: begin
            if (in_valid) begin
              elem_q <= elem_q + W'(1);
              if (elem_q == size_q - W'(1)) begin
                wcnt_q  <= '0;
                state_q <= WAIT;
              end
            end
          end
          WAIT: begin
            // The pooling result is valid POOL_LAT cycles after the last element.
            if (wcnt_q == WC_W'(POOL_LAT - 1)) begin
              out_data_q  <= pool_om;
              out_ch_q    <= ch_q;
              out_valid_q <= 1'b1;
              state_q     <= EMIT;
            end else begin
              wcnt_q <= wcnt_q + WC_W'(1);
            end
          end
          EMIT: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              if (ch_q == num_ch_q - CH_W'(1)) begin
                done_q  <= 1'b1;
                state_q <= FINISH;
              end else begin
                ch_q    <= ch_q + CH_W'(1);
                state_q <= CLEAR;
              end
            end
          end
          FINISH: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready    = (state_q == STREAM);
  assign pool_clr    = (state_q == CLEAR);
  assign pool_en     = (state_q == CLEAR) || (state_q == STREAM) || (state_q == WAIT);
  assign pool_im     = ((state_q == STREAM) && in_valid) ? in_data : '0;
  assign busy        = busy_q;
  assign done        = done_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ch      = out_ch_q;
  assign dbg_state_o = state_q;

endmodule
